// File: rtl/vga_line_fetch_sched.sv
// Line-burst request scheduler and show-ahead pixel path for VGA scan-out.
// Keeps at most PREFETCH_LINES lines requested ahead of the display.
module vga_line_fetch_sched #(
  parameter int                H_DISP          = 1024,
  parameter int                V_DISP          = 768,
  parameter int                ADDR_W          = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
  parameter int                PREFETCH_LINES  = 2,
  parameter logic [15:0]       UNDERFLOW_COLOR = 16'hF800
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic              vga_vs,
  input  logic              data_req,
  output logic [15:0]       pixel_data,
  input  logic [15:0]       fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              fifo_flush,
  output logic              line_req,
  output logic [ADDR_W-1:0] line_addr,
  input  logic              line_ack,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);

  localparam int CW = $clog2(V_DISP + 1);

  typedef enum logic [2:0] {
    IDLE, FLUSH, WAIT_SLOT, REQ, DONE
  } state_e;

  state_e            state_q, state_d;
  logic              vs_q, dreq_q;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              flush_q, flush_d;
  logic              uf_q, uf_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [CW-1:0]     iss_q, iss_d;
  logic [CW-1:0]     con_q, con_d;
  logic              pend_q, pend_d;
  logic [CW-1:0]     outst;
  logic              vs_rise, dreq_fall;

  assign vs_rise   = vga_vs & ~vs_q;
  assign dreq_fall = ~data_req & dreq_q;
  assign outst     = iss_q - con_q;

  assign fifo_rd_en    = data_req & ~fifo_empty;
  assign pixel_data    = fifo_empty ? UNDERFLOW_COLOR : fifo_rd_data;
  assign fifo_flush    = flush_q;
  assign line_req      = req_q;
  assign line_addr     = addr_q;
  assign underflow     = uf_q;
  assign underflow_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    iss_d   = iss_q;
    con_d   = con_q;
    pend_d  = pend_q;
    uf_d    = uf_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;

    if (dreq_fall && state_q != IDLE && outst != '0)
      con_d = con_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        if (vs_rise) state_d = FLUSH;
      end
      FLUSH: begin
        iss_d   = '0;
        con_d   = '0;
        addr_d  = BASE_ADDR;
        uf_d    = 1'b0;
        pend_d  = 1'b0;
        state_d = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (vs_rise) begin
          state_d = FLUSH;
        end else if (iss_q == CW'(V_DISP)) begin
          state_d = DONE;
        end else if (outst < CW'(PREFETCH_LINES)) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        // request is never withdrawn; a restart waits for the ack
        if (line_ack) begin
          req_d   = 1'b0;
          iss_d   = iss_q + CW'(1);
          addr_d  = addr_q + ADDR_W'(H_DISP);
          state_d = (vs_rise || pend_q) ? FLUSH : WAIT_SLOT;
        end else if (vs_rise) begin
          pend_d = 1'b1;
        end
      end
      DONE: begin
        req_d = 1'b0;
        if (vs_rise) state_d = FLUSH;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == FLUSH) flush_d = 1'b1;

    if (data_req && fifo_empty) begin
      uf_d = 1'b1;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      vs_q    <= 1'b0;
      dreq_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      flush_q <= 1'b0;
      uf_q    <= 1'b0;
      cnt_q   <= '0;
      iss_q   <= '0;
      con_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vga_vs;
      dreq_q  <= data_req;
      req_q   <= req_d;
      addr_q  <= addr_d;
      flush_q <= flush_d;
      uf_q    <= uf_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      con_q   <= con_d;
      pend_q  <= pend_d;
    end
  end

endmodule
